// File: rtl/movegen_lookup_arbiter.sv
// Round-robin arbiter sharing one board-lookup port between N_REQ movegen requesters.
// Grants are suppressed while a 64-square position load streams into the lookup store.
module movegen_lookup_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_pos_valid,
  input  logic                 in_pos_sop,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_rankfile,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           lookup_rankfile,
  input  logic [3:0]           lookup_piece,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [3:0]           rsp_piece,
  output logic                 load_busy,
  output logic                 load_done
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_LOADING} state_t;

  state_t                    state_q, state_d;
  logic [6:0]                cnt_q, cnt_d;
  logic [IW-1:0]             rr_q, rr_d;
  logic [7:0]                rankfile_q, rankfile_d;
  logic [LOOKUP_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]             tag_idx_q [LOOKUP_LATENCY];
  logic [IW-1:0]             tag_idx_d [LOOKUP_LATENCY];
  logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [3:0]                rsp_piece_q, rsp_piece_d;
  logic                      done_q, done_d;

  logic [N_REQ-1:0]          grant;
  logic [IW-1:0]             grant_idx;
  logic [IW-1:0]             scan_idx;
  logic                      grant_any;
  logic                      sop_beat;

  assign sop_beat = in_pos_valid & in_pos_sop;

  // A sop beat blocks grants in the same cycle so no lookup races the new position.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (state_q == S_IDLE && !sop_beat) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = IW'((int'(rr_q) + k) % N_REQ);
        if (!grant_any && req_valid[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (sop_beat) begin
        state_d = S_LOADING;
        cnt_d   = 7'd1;
      end
    end else if (in_pos_valid) begin
      if (in_pos_sop) begin
        cnt_d = 7'd1;
      end else if (cnt_q == 7'd63) begin
        cnt_d   = 7'd0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_comb begin
    rankfile_d = rankfile_q;
    rr_d       = rr_q;
    if (grant_any) begin
      rankfile_d = req_rankfile[8*grant_idx +: 8];
      rr_d       = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IW'(1);
    end

    // Tag pipeline runs regardless of load state so in-flight lookups always respond.
    tag_vld_d[0] = grant_any;
    tag_idx_d[0] = grant_idx;
    for (int k = 1; k < LOOKUP_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    rsp_valid_d = '0;
    rsp_piece_d = rsp_piece_q;
    if (tag_vld_q[LOOKUP_LATENCY-1]) begin
      rsp_valid_d[tag_idx_q[LOOKUP_LATENCY-1]] = 1'b1;
      rsp_piece_d = lookup_piece;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      rankfile_q  <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k < LOOKUP_LATENCY; k++) tag_idx_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_piece_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      rankfile_q  <= rankfile_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_piece_q <= rsp_piece_d;
      done_q      <= done_d;
    end
  end

  assign req_ready       = grant;
  assign lookup_rankfile = rankfile_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_piece       = rsp_piece_q;
  assign load_busy       = (state_q == S_LOADING);
  assign load_done       = done_q;

endmodule

// File: tb/tb_movegen_lookup_arbiter.sv
// Scoreboard bench for movegen_lookup_arbiter: grants pushed at issue, responses popped by a monitor.
module tb_movegen_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_pos_valid, in_pos_sop;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [31:0] req_rankfile;
  logic [7:0]  lookup_rankfile;
  logic [3:0]  lookup_piece, rsp_piece;
  logic        load_busy, load_done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] piece;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  movegen_lookup_arbiter #(.N_REQ(4), .LOOKUP_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .in_pos_valid(in_pos_valid), .in_pos_sop(in_pos_sop),
    .req_valid(req_valid), .req_rankfile(req_rankfile), .req_ready(req_ready),
    .lookup_rankfile(lookup_rankfile), .lookup_piece(lookup_piece),
    .rsp_valid(rsp_valid), .rsp_piece(rsp_piece),
    .load_busy(load_busy), .load_done(load_done)
  );

  // Lookup store model: piece code derived from the square (0x12 -> 5).
  function automatic logic [3:0] store_f(input logic [7:0] rf);
    return rf[3:0] + rf[7:4] + 4'd2;
  endfunction

  assign lookup_piece = store_f(lookup_rankfile);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at negedge before the accepting edge.
  task automatic expect_grant(input int idx);
    logic [3:0] oh;
    logic [7:0] rf;
    oh = 4'b0001 << idx;
    rf = req_rankfile[8*idx +: 8];
    check("req_ready", req_ready, oh);
    sb.push_back('{vld: oh, piece: store_f(rf)});
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", rsp_valid, mon_e.vld);
        check("rsp_piece", rsp_piece, mon_e.piece);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_pos_valid = 1'b0; in_pos_sop = 1'b0; req_valid = 4'b0;
    req_rankfile = {8'h4D, 8'h3C, 8'h27, 8'h12};
    step(); step();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_piece", rsp_piece, 0);
    check("rst_lookup_rf", lookup_rankfile, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    step();

    // single lookup, latency 1
    req_valid = 4'b0001;
    @(negedge clk); expect_grant(0);
    step(); req_valid = 4'b0;
    @(negedge clk);
    check("t1_lookup_rf", lookup_rankfile, 8'h12);
    check("t1_rsp_early", rsp_valid, 0);
    step(); step(); step();

    // pointer back to 0, full contention round robin
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); expect_grant(c % 4);
      step();
    end

    // wrap search from pointer 2
    req_valid = 4'b0010;
    @(negedge clk); expect_grant(1); step();
    req_valid = 4'b0011;
    @(negedge clk); expect_grant(0); step();
    @(negedge clk); expect_grant(1); step();

    // contiguous 64-beat load with all requesters asking
    req_valid = 4'b1111;
    for (int b = 1; b <= 64; b++) begin
      in_pos_valid = 1'b1; in_pos_sop = (b == 1);
      @(negedge clk);
      check("t4_ready_blocked", req_ready, 0);
      if (b > 1) check("t4_busy", load_busy, 1);
      check("t4_done_low", load_done, 0);
      step();
    end
    in_pos_valid = 1'b0; in_pos_sop = 1'b0;
    @(negedge clk);
    check("t4_busy_clear", load_busy, 0);
    check("t4_done_pulse", load_done, 1);
    expect_grant(2);
    step(); req_valid = 4'b0;
    @(negedge clk);
    check("t4_done_once", load_done, 0);
    step();

    // gapped load with restart at beat 30
    req_valid = 4'b0001;
    for (int b = 1; b <= 93; b++) begin
      if (b % 2 == 0) begin
        in_pos_valid = 1'b0; in_pos_sop = 1'b0;
        @(negedge clk);
        check("t5_gap_ready", req_ready, 0);
        check("t5_gap_busy", load_busy, 1);
        check("t5_gap_done", load_done, 0);
        step();
      end
      in_pos_valid = 1'b1; in_pos_sop = (b == 1 || b == 30);
      @(negedge clk);
      check("t5_ready", req_ready, 0);
      if (b > 1) check("t5_busy", load_busy, 1);
      check("t5_done_low", load_done, 0);
      step();
    end
    in_pos_valid = 1'b0; in_pos_sop = 1'b0; req_valid = 4'b0;
    @(negedge clk);
    check("t5_done_pulse", load_done, 1);
    check("t5_busy_clear", load_busy, 0);
    step();

    // accept then sop: response still delivered
    req_valid = 4'b1000;
    @(negedge clk); expect_grant(3);
    step();
    req_valid = 4'b0; in_pos_valid = 1'b1; in_pos_sop = 1'b1;
    @(negedge clk); check("t6_sop_ready", req_ready, 0);
    step();
    in_pos_sop = 1'b0;
    step(); step();
    @(negedge clk); check("t6_busy", load_busy, 1);
    rst = 1'b1; step();
    rst = 1'b0; in_pos_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", load_busy, 0);
    check("t6_rst_done", load_done, 0);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_piece", rsp_piece, 0);
    check("t6_rst_lookup_rf", lookup_rankfile, 0);
    check("t6_rst_ready", req_ready, 0);
    step();

    // reset with a tag in flight drops the response
    req_valid = 4'b0001;
    @(negedge clk); check("t6_tag_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_dropped_rsp", rsp_valid, 0);
    check("t6_dropped_rf", lookup_rankfile, 0);
    step(); step(); step();

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
